apb_completer: RTL and testbench

//  APB completer (responder): register-file peripheral answering the bridge's read/write transfers.

---
 rtl/apb_completer.sv | 157 +++++++++++++++
 tb/tb_apb_completer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_completer.sv
// APB completer: word-addressed register file with PPROT region checks and fixed wait states.
// Optional byte-lane write strobes are enabled by defining APB_PSTRB_EN.
module apb_completer #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [2:0]              pprot,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [2:0]            prot_q, prot_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NB-1:0]         strb_q, strb_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic [IW-1:0] idx_c;
  logic [2:0]    req_c;
  logic          range_err_c;
  logic          err_c;

  // Decode and access checks all work from the values latched in the setup phase.
  assign idx_c = addr_q[IW+1:2];
  assign req_c = {addr_q[ADDR_WIDTH-3], addr_q[ADDR_WIDTH-2], addr_q[ADDR_WIDTH-1]};

  generate
    if (ADDR_WIDTH - 3 > IW + 2) begin : g_range
      assign range_err_c = |addr_q[ADDR_WIDTH-4:IW+2];
    end else begin : g_norange
      assign range_err_c = 1'b0;
    end
  endgenerate

  assign err_c = (addr_q[1:0] != 2'b00) || range_err_c || ((req_c & ~prot_q) != 3'b000);

`ifndef APB_PSTRB_EN
  logic unused_strb_c;
  assign unused_strb_c = ^strb_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    prot_d    = prot_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    mem_d     = mem_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (psel && !penable) begin
          addr_d  = paddr;
          write_d = pwrite;
          prot_d  = pprot;
          wdata_d = pwdata;
          strb_d  = pstrb;
          cnt_d   = CW'(WAIT_STATES);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!psel) begin
          // Bridge dropped select mid-transfer: answer with an error, touch nothing.
          state_d   = S_RESP;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end else if (penable) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            state_d  = S_RESP;
            pready_d = 1'b1;
            if (err_c) begin
              pslverr_d = 1'b1;
            end else if (write_q) begin
`ifdef APB_PSTRB_EN
              for (int i = 0; i < int'(NB); i++) begin
                if (strb_q[i]) mem_d[idx_c][8*i +: 8] = wdata_q[8*i +: 8];
              end
`else
              mem_d[idx_c] = wdata_q;
`endif
            end else begin
              prdata_d = mem_q[idx_c];
            end
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      prot_q    <= 3'b000;
      wdata_q   <= '0;
      strb_q    <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      prot_q    <= prot_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      mem_q     <= mem_d;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_completer.sv
// Bench for apb_completer (default parameters): vector table of transfers plus abort/hold/reset sequences.
module tb_apb_completer;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel, penable, pwrite;
  logic [2:0]  pprot;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;

  int checks = 0;
  int errors = 0;

`ifdef APB_PSTRB_EN
  localparam logic [31:0] EXP_STRB3 = 32'h1234FFFF;
  localparam logic [31:0] EXP_STRB0 = 32'hCAFEF00D;
`else
  localparam logic [31:0] EXP_STRB3 = 32'hFFFFFFFF;
  localparam logic [31:0] EXP_STRB0 = 32'h00000000;
`endif

  apb_completer dut (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .pprot   (pprot),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .pstrb   (pstrb),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic [2:0] prot,
                              input logic exp_err, input logic [31:0] exp_rdata);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.prot = prot;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // One full transfer; latency counts rising edges from the edge that samples the setup phase.
  task automatic xfer(input string tag, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot, input int hold,
                      input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat);
    int   lat;
    logic got, err;
    logic [31:0] rdata;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb; pprot = prot;
    @(posedge pclk); #1;
    lat = 1;
    repeat (hold) begin
      @(negedge pclk);
      chk({tag, "_hold_pready"}, 32'(pready), 32'h0);
      @(posedge pclk); #1;
      lat++;
    end
    penable = 1'b1;
    got = 1'b0; err = 1'b0; rdata = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge pclk);
      if (pready) begin
        got = 1'b1; err = pslverr; rdata = prdata;
      end else begin
        @(posedge pclk);
        lat++;
      end
    end
    chk({tag, "_timeout"}, 32'(got), 32'h1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_pslverr"}, 32'(err), 32'(exp_err));
    chk({tag, "_prdata"}, rdata, exp_rdata);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    chk({tag, "_pulse"}, 32'(pready), 32'h0);
  endtask

  initial begin
    vecs[0]  = mk(1'b1, 32'h00000004, 32'hDEADBEEF, 4'hF, 3'b000, 1'b0, 32'h0);
    vecs[1]  = mk(1'b0, 32'h00000004, 32'h0,        4'hF, 3'b000, 1'b0, 32'hDEADBEEF);
    vecs[2]  = mk(1'b0, 32'h00000003, 32'h0,        4'hF, 3'b000, 1'b1, 32'h0);
    vecs[3]  = mk(1'b0, 32'h00000040, 32'h0,        4'hF, 3'b000, 1'b1, 32'h0);
    vecs[4]  = mk(1'b1, 32'h00000040, 32'h11111111, 4'hF, 3'b000, 1'b1, 32'h0);
    vecs[5]  = mk(1'b0, 32'h00000000, 32'h0,        4'hF, 3'b000, 1'b0, 32'h0);
    vecs[6]  = mk(1'b0, 32'h00000004, 32'h0,        4'hF, 3'b000, 1'b0, 32'hDEADBEEF);
    vecs[7]  = mk(1'b1, 32'hE0000008, 32'hA5A5A5A5, 4'hF, 3'b111, 1'b0, 32'h0);
    vecs[8]  = mk(1'b0, 32'hE0000008, 32'h0,        4'hF, 3'b110, 1'b1, 32'h0);
    vecs[9]  = mk(1'b0, 32'hE0000008, 32'h0,        4'hF, 3'b101, 1'b1, 32'h0);
    vecs[10] = mk(1'b0, 32'hE0000008, 32'h0,        4'hF, 3'b011, 1'b1, 32'h0);
    vecs[11] = mk(1'b0, 32'hE0000008, 32'h0,        4'hF, 3'b111, 1'b0, 32'hA5A5A5A5);
    vecs[12] = mk(1'b0, 32'h00000008, 32'h0,        4'hF, 3'b000, 1'b0, 32'hA5A5A5A5);
    vecs[13] = mk(1'b1, 32'h00000008, 32'h12345678, 4'hF, 3'b000, 1'b0, 32'h0);
    vecs[14] = mk(1'b1, 32'h00000008, 32'hFFFFFFFF, 4'h3, 3'b000, 1'b0, 32'h0);
    vecs[15] = mk(1'b0, 32'h00000008, 32'h0,        4'hF, 3'b000, 1'b0, EXP_STRB3);
    vecs[16] = mk(1'b1, 32'h0000003C, 32'hCAFEF00D, 4'hF, 3'b000, 1'b0, 32'h0);
    vecs[17] = mk(1'b0, 32'h0000003C, 32'h0,        4'hF, 3'b000, 1'b0, 32'hCAFEF00D);
    vecs[18] = mk(1'b1, 32'h0000003C, 32'h0,        4'h0, 3'b000, 1'b0, 32'h0);
    vecs[19] = mk(1'b0, 32'h0000003C, 32'h0,        4'hF, 3'b000, 1'b0, EXP_STRB0);
    vecs[20] = mk(1'b1, 32'h00000005, 32'h99999999, 4'hF, 3'b000, 1'b1, 32'h0);
    vecs[21] = mk(1'b0, 32'h00000004, 32'h0,        4'hF, 3'b000, 1'b0, 32'hDEADBEEF);
    vecs[22] = mk(1'b0, 32'h20000000, 32'h0,        4'hF, 3'b011, 1'b1, 32'h0);

    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    pprot = 3'b000; paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    chk("reset_pready", 32'(pready), 32'h0);
    chk("reset_pslverr", 32'(pslverr), 32'h0);
    chk("reset_prdata", prdata, 32'h0);

    // Access phase without a preceding setup must be ignored.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b1; paddr = 32'h4; pwrite = 1'b0;
    repeat (4) begin
      @(negedge pclk);
      chk("nosetup_pready", 32'(pready), 32'h0);
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;

    for (int i = 0; i < NV; i++)
      xfer($sformatf("v%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
           vecs[i].prot, 0, vecs[i].exp_err, vecs[i].exp_rdata, 3);

    // Abort: select dropped in the access phase.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h55555555;
    pstrb = 4'hF; pprot = 3'b000;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b1;
    @(negedge pclk);
    chk("abort_early_pready", 32'(pready), 32'h0);
    @(negedge pclk);
    chk("abort_pready", 32'(pready), 32'h1);
    chk("abort_pslverr", 32'(pslverr), 32'h1);
    chk("abort_prdata", prdata, 32'h0);
    @(posedge pclk); #1;
    penable = 1'b0;
    @(negedge pclk);
    chk("abort_pulse", 32'(pready), 32'h0);
    xfer("abort_rd", 1'b0, 32'h4, 32'h0, 4'hF, 3'b000, 0, 1'b0, 32'hDEADBEEF, 3);

    // Setup held for two extra cycles: wait counter must not run.
    xfer("hold_rd", 1'b0, 32'h4, 32'h0, 4'hF, 3'b000, 2, 1'b0, 32'hDEADBEEF, 5);

    // Reset in the access phase of a write.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h77777777;
    pstrb = 4'hF; pprot = 3'b000;
    @(posedge pclk); #1;
    penable = 1'b1; preset = 1'b1;
    repeat (3) begin
      @(negedge pclk);
      chk("rstmid_pready", 32'(pready), 32'h0);
    end
    @(posedge pclk); #1;
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    xfer("rstmid_rd4", 1'b0, 32'h4, 32'h0, 4'hF, 3'b000, 0, 1'b0, 32'h0, 3);
    xfer("rstmid_rd8", 1'b0, 32'h8, 32'h0, 4'hF, 3'b000, 0, 1'b0, 32'h0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
